// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: serial line, frame configuration and received-word signals of the UART receiver.
interface uart_rx_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [5:0]            Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Parity_Error;
  logic                  Stop_Error;
  modport master (output RX_IN, PAR_EN, PAR_TYP, Prescale,
                  input  P_DATA, Data_Valid, Parity_Error, Stop_Error);
  modport slave  (input  RX_IN, PAR_EN, PAR_TYP, Prescale,
                  output P_DATA, Data_Valid, Parity_Error, Stop_Error);
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receiver (start, DATA_WIDTH bits LSB first, optional parity, one stop).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around the bit centre.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_ctrl_if.slave bus
);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state;
  logic [5:0]            edge_cnt, pre, half;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  pen, ptyp, par_err, stop_err;
  logic                  last, dec, bit_v, start_frame;
  assign half = pre >> 1;
  assign last = edge_cnt == pre - 6'd1;
  assign start_frame = !bus.RX_IN && (state == IDLE || (state == STOP && last));
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] smp;
  assign dec   = edge_cnt == half + 6'd1;
  assign bit_v = (smp[0] & smp[1]) | (smp[0] & bus.RX_IN) | (smp[1] & bus.RX_IN);
  always_ff @(posedge CLK) begin
    if (RST) smp <= 2'b11;
    else begin
      if (edge_cnt == half - 6'd1) smp[0] <= bus.RX_IN;
      if (edge_cnt == half) smp[1] <= bus.RX_IN;
    end
  end
`else
  assign dec   = edge_cnt == half;
  assign bit_v = bus.RX_IN;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      edge_cnt         <= '0;
      bit_cnt          <= '0;
      shreg            <= '0;
      pre              <= '0;
      pen              <= 1'b0;
      ptyp             <= 1'b0;
      par_err          <= 1'b0;
      stop_err         <= 1'b0;
      bus.P_DATA       <= '0;
      bus.Data_Valid   <= 1'b0;
      bus.Parity_Error <= 1'b0;
      bus.Stop_Error   <= 1'b0;
    end else begin
      bus.Data_Valid   <= 1'b0;
      bus.Parity_Error <= 1'b0;
      bus.Stop_Error   <= 1'b0;
      edge_cnt         <= (state == IDLE || last) ? 6'd0 : edge_cnt + 6'd1;
      case (state)
        IDLE:    if (!bus.RX_IN) state <= START;
        START:   if (dec && bit_v) state <= IDLE;
                 else if (last) state <= DATA;
        DATA: begin
          if (dec) shreg <= {bit_v, shreg[DATA_WIDTH-1:1]};
          if (last) begin
            bit_cnt <= (bit_cnt == BW'(DATA_WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == BW'(DATA_WIDTH - 1)) state <= pen ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (dec) par_err <= bit_v != (^shreg ^ ptyp);
          if (last) state <= STOP;
        end
        STOP: begin
          if (dec) stop_err <= !bit_v;
          if (last) begin
            bus.Parity_Error <= par_err;
            bus.Stop_Error   <= stop_err;
            bus.Data_Valid   <= !par_err && !stop_err;
            if (!par_err && !stop_err) bus.P_DATA <= shreg;
            state <= bus.RX_IN ? IDLE : START;
          end
        end
        default: state <= IDLE;
      endcase
      // frame configuration is frozen at the first low tick of every start bit
      if (start_frame) begin
        pre      <= bus.Prescale;
        pen      <= bus.PAR_EN;
        ptyp     <= bus.PAR_TYP;
        par_err  <= 1'b0;
        stop_err <= 1'b0;
      end
    end
  end
endmodule
